// File: rtl/seg_access_ctrl.sv
// Segmented-memory access controller: decodes a request address into a one-hot bank
// select and sequences each access through programmable per-segment wait states.
module seg_access_ctrl #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned SEG_BITS = 3,
   parameter int unsigned WAIT_W   = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req,
   input  logic                         we,
   input  logic [ADDR_W-1:0]            addr,
   input  logic                         cfg_we,
   input  logic [SEG_BITS-1:0]          cfg_seg,
   input  logic [WAIT_W-1:0]            cfg_wait,
   input  logic                         cfg_ro,
   output logic                         busy,
   output logic [(2**SEG_BITS)-1:0]     cs,
   output logic [SEG_BITS-1:0]          seg,
   output logic [ADDR_W-SEG_BITS-1:0]   offset,
   output logic                         wr,
   output logic                         ack,
   output logic                         err
);

   localparam int unsigned NSEG  = 2 ** SEG_BITS;
   localparam int unsigned OFF_W = ADDR_W - SEG_BITS;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StAccess = 2'd1;
   localparam logic [1:0] StDone   = 2'd2;
   localparam logic [1:0] StErr    = 2'd3;

   localparam logic [WAIT_W-1:0] CntOne  = WAIT_W'(1);
   localparam logic [NSEG-1:0]   SelOne  = NSEG'(1);

   logic [1:0]          state_q, state_d;
   logic [SEG_BITS-1:0] seg_q, seg_d;
   logic [OFF_W-1:0]    offset_q, offset_d;
   logic                wr_q, wr_d;
   logic [WAIT_W-1:0]   cnt_q, cnt_d;

   logic [WAIT_W-1:0]   wait_q [NSEG];
   logic                ro_q   [NSEG];

   logic [SEG_BITS-1:0] req_seg;

   assign req_seg = addr[ADDR_W-1 -: SEG_BITS];

   // Per-segment configuration; an accept on the same edge sees the pre-write values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NSEG; i++) begin
            wait_q[i] <= '0;
            ro_q[i]   <= 1'b0;
         end
      end else if (cfg_we) begin
         wait_q[cfg_seg] <= cfg_wait;
         ro_q[cfg_seg]   <= cfg_ro;
      end
   end

   always_comb begin
      state_d  = state_q;
      seg_d    = seg_q;
      offset_d = offset_q;
      wr_d     = wr_q;
      cnt_d    = cnt_q;
      case (state_q)
         StIdle: begin
            if (req) begin
               seg_d    = req_seg;
               offset_d = addr[OFF_W-1:0];
               wr_d     = we;
               cnt_d    = wait_q[req_seg];
               // Reads never consult the write-protect flag.
               state_d  = (we && ro_q[req_seg]) ? StErr : StAccess;
            end
         end
         StAccess: begin
            if (cnt_q == '0) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - CntOne;
            end
         end
         StDone:  state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         seg_q    <= '0;
         offset_q <= '0;
         wr_q     <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         seg_q    <= seg_d;
         offset_q <= offset_d;
         wr_q     <= wr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      busy   = (state_q != StIdle);
      cs     = (state_q == StAccess) ? (SelOne << seg_q) : '0;
      ack    = (state_q == StDone);
      err    = (state_q == StErr);
      seg    = seg_q;
      offset = offset_q;
      wr     = wr_q;
   end

endmodule

// File: tb/tb_seg_access_ctrl.sv
// Bench for seg_access_ctrl: a transaction-timeline model checked every cycle, plus
// directed scenarios with hand-computed cycle counts.
module tb_seg_access_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic        we;
   logic [15:0] addr;
   logic        cfg_we;
   logic [2:0]  cfg_seg;
   logic [3:0]  cfg_wait;
   logic        cfg_ro;
   logic        busy;
   logic [7:0]  cs;
   logic [2:0]  seg;
   logic [12:0] offset;
   logic        wr;
   logic        ack;
   logic        err;

   int checks   = 0;
   int failures = 0;

   seg_access_ctrl #(
      .ADDR_W   (16),
      .SEG_BITS (3),
      .WAIT_W   (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .we       (we),
      .addr     (addr),
      .cfg_we   (cfg_we),
      .cfg_seg  (cfg_seg),
      .cfg_wait (cfg_wait),
      .cfg_ro   (cfg_ro),
      .busy     (busy),
      .cs       (cs),
      .seg      (seg),
      .offset   (offset),
      .wr       (wr),
      .ack      (ack),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs as seen by the DUT at each rising edge.
   logic        s_rst_n, s_req, s_we, s_cfg_we, s_cfg_ro;
   logic [15:0] s_addr;
   logic [2:0]  s_cfg_seg;
   logic [3:0]  s_cfg_wait;

   always @(posedge clk) begin
      s_rst_n    <= rst_n;
      s_req      <= req;
      s_we       <= we;
      s_addr     <= addr;
      s_cfg_we   <= cfg_we;
      s_cfg_seg  <= cfg_seg;
      s_cfg_wait <= cfg_wait;
      s_cfg_ro   <= cfg_ro;
   end

   // Timeline model: an accept at edge e0 with wait w occupies cycles e0..e0+w+1
   // (select for w+1 cycles, then ack); a rejected write occupies cycle e0 only.
   int          k      = 0;
   bit          mvalid = 0;
   int          kind   = 0;
   int          e0     = 0;
   int          w      = 0;
   int          free_e = 0;
   int          m_wait [8];
   bit          m_ro   [8];
   logic [2:0]  m_seg;
   logic [12:0] m_off;
   logic        m_wr;

   always @(negedge clk) begin
      int sg;
      logic       eb, ea, ee;
      logic [7:0] ecs;
      k++;
      if (s_rst_n !== 1'b1) begin
         mvalid = 1;
         kind   = 0;
         free_e = k + 1;
         m_seg  = '0;
         m_off  = '0;
         m_wr   = 1'b0;
         for (int i = 0; i < 8; i++) begin
            m_wait[i] = 0;
            m_ro[i]   = 0;
         end
      end else if (mvalid) begin
         if (s_req && k >= free_e) begin
            sg    = int'(s_addr[15:13]);
            e0    = k;
            w     = m_wait[sg];
            m_seg = s_addr[15:13];
            m_off = s_addr[12:0];
            m_wr  = s_we;
            if (s_we && m_ro[sg]) begin
               kind   = 2;
               free_e = k + 2;
            end else begin
               kind   = 1;
               free_e = k + w + 3;
            end
         end
         if (s_cfg_we) begin
            m_wait[s_cfg_seg] = int'(s_cfg_wait);
            m_ro[s_cfg_seg]   = s_cfg_ro;
         end
      end
      if (mvalid) begin
         eb  = 1'b0;
         ea  = 1'b0;
         ee  = 1'b0;
         ecs = '0;
         if (kind == 1) begin
            if (k >= e0 && k <= e0 + w) ecs = 8'd1 << m_seg;
            ea = (k == e0 + w + 1);
            eb = (k >= e0 && k <= e0 + w + 1);
         end else if (kind == 2) begin
            ee = (k == e0);
            eb = ee;
         end
         chk("model_busy",   32'(busy),   32'(eb));
         chk("model_cs",     32'(cs),     32'(ecs));
         chk("model_ack",    32'(ack),    32'(ea));
         chk("model_err",    32'(err),    32'(ee));
         chk("model_seg",    32'(seg),    32'(m_seg));
         chk("model_offset", 32'(offset), 32'(m_off));
         chk("model_wr",     32'(wr),     32'(m_wr));
      end
   end

   // Issues one request from an idle negedge and records what the bank side saw.
   task automatic txn(input logic w_i, input logic [15:0] a, output int n_cs,
                      output int ack_cyc, output int n_err, output int n_busy,
                      output logic [7:0] cs_seen);
      we      = w_i;
      addr    = a;
      req     = 1'b1;
      n_cs    = 0;
      ack_cyc = 0;
      n_err   = 0;
      n_busy  = 0;
      cs_seen = '0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         req    = 1'b0;
         cfg_we = 1'b0;
         if (cs != '0) begin
            n_cs++;
            cs_seen = cs_seen | cs;
         end
         if (ack) ack_cyc = i;
         if (err) n_err++;
         if (busy) n_busy++;
         else break;
      end
   endtask

   task automatic cfg(input logic [2:0] s, input logic [3:0] wt, input logic ro);
      cfg_we   = 1'b1;
      cfg_seg  = s;
      cfg_wait = wt;
      cfg_ro   = ro;
      @(negedge clk);
      cfg_we   = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   int         n_cs, ack_cyc, n_err, n_busy;
   logic [7:0] cs_seen;
   int         starts [4];
   int         ns;
   int         cs_total;
   logic [7:0] pcs;

   initial begin
      rst_n    = 1'b0;
      req      = 1'b1;
      we       = 1'b0;
      addr     = 16'hA123;
      cfg_we   = 1'b0;
      cfg_seg  = '0;
      cfg_wait = '0;
      cfg_ro   = 1'b0;

      // Reset held two cycles with req asserted.
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cs",   32'(cs),   32'd0);
      chk("rst_ack",  32'(ack),  32'd0);
      chk("rst_err",  32'(err),  32'd0);
      rst_n = 1'b1;

      txn(1'b0, 16'hA123, n_cs, ack_cyc, n_err, n_busy, cs_seen);
      chk("rd_cs_cycles", n_cs, 1);
      chk("rd_cs_value",  32'(cs_seen), 32'h20);
      chk("rd_ack_cycle", ack_cyc, 2);
      chk("rd_seg",       32'(seg), 32'd5);
      chk("rd_offset",    32'(offset), 32'h0123);

      // Wait states on segment 2.
      cfg(3'd2, 4'd3, 1'b0);
      txn(1'b0, 16'h4000, n_cs, ack_cyc, n_err, n_busy, cs_seen);
      chk("ws_cs_cycles", n_cs, 4);
      chk("ws_cs_value",  32'(cs_seen), 32'h04);
      chk("ws_ack_cycle", ack_cyc, 5);
      chk("ws_busy",      n_busy, 5);

      // Write protection on segment 7.
      cfg(3'd7, 4'd0, 1'b1);
      txn(1'b1, 16'hFFFF, n_cs, ack_cyc, n_err, n_busy, cs_seen);
      chk("wp_err_cycles", n_err, 1);
      chk("wp_cs_cycles",  n_cs, 0);
      chk("wp_ack",        ack_cyc, 0);
      chk("wp_busy",       n_busy, 1);
      txn(1'b0, 16'hFFFF, n_cs, ack_cyc, n_err, n_busy, cs_seen);
      chk("wp_rd_cs",      32'(cs_seen), 32'h80);
      chk("wp_rd_ack",     ack_cyc, 2);
      chk("wp_rd_err",     n_err, 0);

      // Maximum wait with req held high.
      cfg(3'd0, 4'd15, 1'b0);
      ns       = 0;
      cs_total = 0;
      pcs      = '0;
      for (int i = 0; i < 4; i++) starts[i] = 0;
      addr = 16'h0000;
      we   = 1'b0;
      req  = 1'b1;
      for (int i = 1; i <= 75; i++) begin
         @(negedge clk);
         if (cs != '0 && pcs == '0 && ns < 4) begin
            starts[ns] = i;
            ns++;
         end
         if (cs != '0 && i <= 54) cs_total++;
         pcs = cs;
      end
      req = 1'b0;
      wait_idle();
      chk("b2b_starts",    ns, 4);
      chk("b2b_interval1", starts[1] - starts[0], 18);
      chk("b2b_interval2", starts[2] - starts[1], 18);
      chk("b2b_interval3", starts[3] - starts[2], 18);
      chk("b2b_cs_total",  cs_total, 48);

      // Config write on the accept edge: old wait applies to this access only.
      cfg_we   = 1'b1;
      cfg_seg  = 3'd1;
      cfg_wait = 4'd5;
      cfg_ro   = 1'b0;
      txn(1'b0, 16'h2000, n_cs, ack_cyc, n_err, n_busy, cs_seen);
      chk("col_old_cs",  n_cs, 1);
      chk("col_old_ack", ack_cyc, 2);
      txn(1'b0, 16'h2000, n_cs, ack_cyc, n_err, n_busy, cs_seen);
      chk("col_new_cs",  n_cs, 6);
      chk("col_new_ack", ack_cyc, 7);

      // Reset in the middle of a long access.
      cfg(3'd3, 4'd10, 1'b0);
      addr = 16'h6000;
      we   = 1'b0;
      req  = 1'b1;
      @(negedge clk);
      req = 1'b0;
      chk("mid_cs_on", 32'(cs), 32'h08);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_cs_off", 32'(cs),   32'd0);
      chk("mid_busy",   32'(busy), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_no_ack", 32'(ack), 32'd0);
      end
      txn(1'b0, 16'h6000, n_cs, ack_cyc, n_err, n_busy, cs_seen);
      chk("mid_cfg_cleared_cs", n_cs, 1);
      chk("mid_cfg_cleared_ack", ack_cyc, 2);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1);
   end

endmodule
